// File: rtl/alu_wide_seq.sv
// Byte-serial sequencer driving a shared 8-bit ALU for NBYTES*8-bit ops.
// LSB byte first, carry/borrow chained through a register between bytes.
module alu_wide_seq #(
  parameter int NBYTES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            req_op,
  input  logic [8*NBYTES-1:0]   req_a,
  input  logic [8*NBYTES-1:0]   req_b,
  input  logic                  req_carry_in,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [8*NBYTES-1:0]   resp_result,
  output logic                  resp_carry,
  output logic                  resp_zero,
  output logic                  resp_neg,
  output logic                  resp_overflow,
  output logic [2:0]            alu_op,
  output logic [7:0]            alu_a,
  output logic [7:0]            alu_b,
  output logic                  alu_carry_in,
  input  logic [7:0]            alu_out,
  input  logic                  alu_flag_carry,
  input  logic                  alu_flag_zero,
  input  logic                  alu_flag_neg,
  input  logic                  alu_flag_overflow
);

  localparam int W  = 8 * NBYTES;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_SHL = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_COMMIT,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [2:0]    op_q, op_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic          cin_q, cin_d;
  logic          cy_q, cy_d;
  logic [W-1:0]  acc_q, acc_d;
  logic          zacc_q, zacc_d;
  logic          neg_q, neg_d;
  logic          ovf_q, ovf_d;
  logic          vld_q, vld_d;
  logic [W-1:0]  res_q, res_d;
  logic          rc_q, rc_d;
  logic          rz_q, rz_d;
  logic          rn_q, rn_d;
  logic          rv_q, rv_d;
  logic          chain_op;

  assign chain_op = (op_q == OP_ADD) || (op_q == OP_SUB) ||
                    (op_q == OP_SHL);

  assign req_ready     = (state_q == S_IDLE) && reset_n;
  assign resp_valid    = vld_q;
  assign resp_result   = res_q;
  assign resp_carry    = rc_q;
  assign resp_zero     = rz_q;
  assign resp_neg      = rn_q;
  assign resp_overflow = rv_q;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    cin_d        = cin_q;
    cy_d         = cy_q;
    acc_d        = acc_q;
    zacc_d       = zacc_q;
    neg_d        = neg_q;
    ovf_d        = ovf_q;
    vld_d        = vld_q;
    res_d        = res_q;
    rc_d         = rc_q;
    rz_d         = rz_q;
    rn_d         = rn_q;
    rv_d         = rv_q;
    alu_op       = 3'b000;
    alu_a        = 8'h00;
    alu_b        = 8'h00;
    alu_carry_in = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d    = req_op;
          a_d     = req_a;
          b_d     = req_b;
          cin_d   = req_carry_in;
          idx_d   = '0;
          zacc_d  = 1'b1;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_op = op_q;
        alu_a  = a_q[8*idx_q +: 8];
        alu_b  = b_q[8*idx_q +: 8];
        // byte 0 takes the request carry, later bytes the chained one
        if (chain_op)
          alu_carry_in = (idx_q == '0) ? cin_q : cy_q;
        acc_d[8*idx_q +: 8] = alu_out;
        cy_d   = alu_flag_carry;
        zacc_d = zacc_q & alu_flag_zero;
        neg_d  = alu_flag_neg;
        ovf_d  = alu_flag_overflow;
        if (idx_q == LAST)
          state_d = S_COMMIT;
        else
          idx_d = idx_q + 1'b1;
      end
      S_COMMIT: begin
        res_d   = acc_q;
        rc_d    = chain_op & cy_q;
        rz_d    = zacc_q;
        rn_d    = neg_q;
        rv_d    = ovf_q;
        vld_d   = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (resp_ready) begin
          vld_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      op_q    <= 3'b000;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      cy_q    <= 1'b0;
      acc_q   <= '0;
      zacc_q  <= 1'b0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
      vld_q   <= 1'b0;
      res_q   <= '0;
      rc_q    <= 1'b0;
      rz_q    <= 1'b0;
      rn_q    <= 1'b0;
      rv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      cy_q    <= cy_d;
      acc_q   <= acc_d;
      zacc_q  <= zacc_d;
      neg_q   <= neg_d;
      ovf_q   <= ovf_d;
      vld_q   <= vld_d;
      res_q   <= res_d;
      rc_q    <= rc_d;
      rz_q    <= rz_d;
      rn_q    <= rn_d;
      rv_q    <= rv_d;
    end
  end

endmodule

// File: tb/tb_alu_wide_seq.sv
// Bench for alu_wide_seq: 8-bit ALU model, 16-bit reference model,
// directed literal cases plus randomized ops.
module tb_alu_wide_seq;

  localparam int NB = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic        req_carry_in;
  logic        resp_valid;
  logic        resp_ready;
  logic [15:0] resp_result;
  logic        resp_carry;
  logic        resp_zero;
  logic        resp_neg;
  logic        resp_overflow;
  logic [2:0]  alu_op;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic        alu_carry_in;
  logic [7:0]  alu_out;
  logic        alu_flag_carry;
  logic        alu_flag_zero;
  logic        alu_flag_neg;
  logic        alu_flag_overflow;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] exp_r;
  logic        exp_c, exp_z, exp_n, exp_v;

  always #5 clk = ~clk;

  alu_wide_seq #(.NBYTES(NB)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_op(req_op),
    .req_a(req_a),
    .req_b(req_b),
    .req_carry_in(req_carry_in),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_result(resp_result),
    .resp_carry(resp_carry),
    .resp_zero(resp_zero),
    .resp_neg(resp_neg),
    .resp_overflow(resp_overflow),
    .alu_op(alu_op),
    .alu_a(alu_a),
    .alu_b(alu_b),
    .alu_carry_in(alu_carry_in),
    .alu_out(alu_out),
    .alu_flag_carry(alu_flag_carry),
    .alu_flag_zero(alu_flag_zero),
    .alu_flag_neg(alu_flag_neg),
    .alu_flag_overflow(alu_flag_overflow)
  );

  // shared 8-bit ALU
  logic [8:0] s9;
  always_comb begin
    s9                = 9'h000;
    alu_out           = 8'h00;
    alu_flag_carry    = 1'b0;
    alu_flag_overflow = 1'b0;
    case (alu_op)
      3'd0: begin
        s9 = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_carry_in};
        alu_out = s9[7:0];
        alu_flag_carry = s9[8];
        alu_flag_overflow = (alu_a[7] == alu_b[7]) && (s9[7] != alu_a[7]);
      end
      3'd1: begin
        s9 = {1'b0, alu_a} - {1'b0, alu_b} - {8'h00, alu_carry_in};
        alu_out = s9[7:0];
        alu_flag_carry = s9[8];
        alu_flag_overflow = (alu_a[7] != alu_b[7]) && (s9[7] != alu_a[7]);
      end
      3'd2: alu_out = alu_a & alu_b;
      3'd3: alu_out = alu_a | alu_b;
      3'd4: alu_out = alu_a ^ alu_b;
      3'd5: begin
        alu_out = {alu_a[6:0], alu_carry_in};
        alu_flag_carry = alu_a[7];
      end
      default: alu_out = 8'h00;
    endcase
    alu_flag_zero = (alu_out == 8'h00);
    alu_flag_neg  = alu_out[7];
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // whole-word reference model
  task automatic model(input logic [2:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic cin,
                       output logic [15:0] r, output logic c,
                       output logic z, output logic n, output logic v);
    longint s, sv;
    r = 16'h0; c = 1'b0; v = 1'b0;
    case (op)
      3'd0: begin
        s = longint'(a) + longint'(b) + longint'(cin);
        r = 16'(s);
        c = (s > 65535);
        sv = longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
        v = (sv > 32767) || (sv < -32768);
      end
      3'd1: begin
        s = longint'(a) - longint'(b) - longint'(cin);
        r = 16'(s);
        c = (s < 0);
        sv = longint'($signed(a)) - longint'($signed(b)) - longint'(cin);
        v = (sv > 32767) || (sv < -32768);
      end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: begin
        r = {a[14:0], cin};
        c = a[15];
      end
      default: r = 16'h0;
    endcase
    z = (r == 16'h0);
    n = r[15];
  endtask

  // carry expected into byte i from the low 8*i bits
  function automatic logic carry_into(input logic [2:0] op,
                                      input logic [15:0] a,
                                      input logic [15:0] b,
                                      input logic cin, input int i);
    longint m;
    if (!(op == 3'd0 || op == 3'd1 || op == 3'd5)) return 1'b0;
    if (i == 0) return cin;
    m = (longint'(1) << (8 * i)) - 1;
    case (op)
      3'd0: return (((longint'(a) & m) + (longint'(b) & m) +
                     longint'(cin)) >> (8 * i)) != 0;
      3'd1: return (longint'(a) & m) < ((longint'(b) & m) + longint'(cin));
      default: return a[8*i-1];
    endcase
  endfunction

  // compare process: response checked every cycle it is presented
  always @(negedge clk) begin
    if (reset_n && resp_valid) begin
      chk("resp_result", 32'(resp_result), 32'(exp_r));
      chk("resp_carry", 32'(resp_carry), 32'(exp_c));
      chk("resp_zero", 32'(resp_zero), 32'(exp_z));
      chk("resp_neg", 32'(resp_neg), 32'(exp_n));
      chk("resp_overflow", 32'(resp_overflow), 32'(exp_v));
      chk("req_ready_busy", 32'(req_ready), 32'd0);
    end
  end

  task automatic send(input logic [2:0] op, input logic [15:0] a,
                      input logic [15:0] b, input logic cin,
                      input int hold);
    bit ok;
    int lat;
    ok = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      chk("req_ready_timeout", 32'd0, 32'd1);
      return;
    end
    model(op, a, b, cin, exp_r, exp_c, exp_z, exp_n, exp_v);
    req_valid = 1'b1;
    req_op = op;
    req_a = a;
    req_b = b;
    req_carry_in = cin;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_op = 3'($urandom);
    req_a = 16'($urandom);
    req_b = 16'($urandom);
    req_carry_in = 1'($urandom);
    ok = 0;
    for (lat = 0; lat < 20; lat++) begin
      @(negedge clk);
      if (resp_valid) begin ok = 1; break; end
      if (lat < NB) begin
        chk("alu_op", 32'(alu_op), 32'(op));
        chk("alu_a", 32'(alu_a), 32'(a[8*lat +: 8]));
        chk("alu_b", 32'(alu_b), 32'(b[8*lat +: 8]));
        chk("alu_cin", 32'(alu_carry_in),
            32'(carry_into(op, a, b, cin, lat)));
      end else begin
        chk("alu_idle", {alu_op, alu_a, alu_b, alu_carry_in}, 32'd0);
      end
    end
    chk("latency", 32'(lat), 32'(NB + 1));
    if (!ok) return;
    for (int h = 0; h < hold; h++) begin
      req_valid = 1'b1;
      @(negedge clk);
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    @(negedge clk);
    chk("resp_valid_drop", 32'(resp_valid), 32'd0);
    chk("req_ready_back", 32'(req_ready), 32'd1);
  endtask

  task automatic pin(input string name, input logic [15:0] r,
                     input logic c, input logic z);
    chk({name, "_r"}, 32'(resp_result), 32'(r));
    chk({name, "_c"}, 32'(resp_carry), 32'(c));
    chk({name, "_z"}, 32'(resp_zero), 32'(z));
  endtask

  initial begin
    reset_n = 1'b0;
    req_valid = 1'b0;
    req_op = 3'd0;
    req_a = 16'h0;
    req_b = 16'h0;
    req_carry_in = 1'b0;
    resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_req_ready_rel", 32'(req_ready), 32'd1);
    chk("rst_resp", {resp_valid, resp_carry, resp_zero, resp_neg,
                     resp_overflow, resp_result}, 32'd0);
    chk("rst_alu", {alu_op, alu_a, alu_b, alu_carry_in}, 32'd0);

    send(3'd0, 16'h00FF, 16'h0001, 1'b0, 0);
    pin("add_chain", 16'h0100, 1'b0, 1'b0);
    send(3'd1, 16'h0100, 16'h0001, 1'b0, 1);
    pin("sub_borrow", 16'h00FF, 1'b0, 1'b0);
    send(3'd0, 16'hFFFF, 16'h0001, 1'b0, 0);
    pin("add_wrap", 16'h0000, 1'b1, 1'b1);
    send(3'd0, 16'h7FFF, 16'h0001, 1'b0, 0);
    pin("add_ovf", 16'h8000, 1'b0, 1'b0);
    chk("add_ovf_n", 32'(resp_neg), 32'd1);
    chk("add_ovf_v", 32'(resp_overflow), 32'd1);
    send(3'd5, 16'h8080, 16'h0000, 1'b1, 5);
    pin("shl", 16'h0101, 1'b1, 1'b0);
    send(3'd2, 16'hF0F0, 16'h0FF0, 1'b1, 0);
    pin("and", 16'h00F0, 1'b0, 1'b0);
    send(3'd6, 16'h1234, 16'h5678, 1'b1, 2);
    pin("undef", 16'h0000, 1'b0, 1'b1);
    send(3'd4, 16'hA5A5, 16'h0F0F, 1'b0, 0);
    pin("xor", 16'hAAAA, 1'b0, 1'b0);

    // reset while the second byte is executing
    @(negedge clk);
    req_valid = 1'b1;
    req_op = 3'd0;
    req_a = 16'h1234;
    req_b = 16'h1111;
    req_carry_in = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #2;
    chk("exec_b1_alu_a", 32'(alu_a), 32'h12);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_resp", {resp_valid, resp_carry, resp_zero, resp_neg,
                         resp_overflow, resp_result}, 32'd0);
    chk("mid_rst_alu", {alu_op, alu_a, alu_b, alu_carry_in}, 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("post_rst_ready", 32'(req_ready), 32'd1);
      chk("post_rst_valid", 32'(resp_valid), 32'd0);
    end

    for (int t = 0; t < 60; t++) begin
      send(3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom),
           1'($urandom), int'($urandom_range(0, 3)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
